// File: rtl/pe_pkg.sv
// Shared definitions for the PE bit-serial interface blocks.
package pe_pkg;

  localparam int unsigned DEFAULT_BITWIDTH = 8;
  localparam int unsigned NLANES           = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } feeder_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/bitserial_lane_shifter.sv
// One serial lane: parallel load, right shift (LSB first), otherwise hold.
module bitserial_lane_shifter #(
  parameter int unsigned BITWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                shift,
  input  logic [BITWIDTH-1:0] din,
  output logic                lsb
);

  logic [BITWIDTH-1:0] shreg;

  // load wins over shift so a word can be replaced in the edge its last bit leaves
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

  assign lsb = shreg[0];

endmodule

// File: rtl/bitserial_row_feeder.sv
// Bit-serial transmit end: buffers parallel signed triplets and shifts them out LSB first.
module bitserial_row_feeder
  import pe_pkg::*;
#(
  parameter int unsigned BITWIDTH = DEFAULT_BITWIDTH,
  parameter int unsigned CW       = clog2(BITWIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] din1,
  input  logic [BITWIDTH-1:0] din2,
  input  logic [BITWIDTH-1:0] din3,
  input  logic                hold,
  output logic                out_bit1,
  output logic                out_bit2,
  output logic                out_bit3,
  output logic                out_valid,
  output logic                first_bit,
  output logic                last_bit,
  output logic [CW-1:0]       bit_index
);

  localparam logic [CW-1:0] LAST_IDX = CW'(BITWIDTH - 1);

  feeder_state_t       state;
  logic [BITWIDTH-1:0] din_lane  [NLANES];
  logic [BITWIDTH-1:0] hold_data [NLANES];
  logic                hold_full;
  logic                hold_full_next;
  logic [CW-1:0]       cnt;
  logic                accept;
  logic                word_end;
  logic                load;
  logic                shift;
  logic [NLANES-1:0]   lane_lsb;
  logic [NLANES-1:0]   bits;

  assign din_lane[0] = din1;
  assign din_lane[1] = din2;
  assign din_lane[2] = din3;

  always_comb begin
    accept         = in_valid && in_ready;
    word_end       = (state == SHIFT) && !hold && (cnt == LAST_IDX);
    load           = ((state == IDLE) && hold_full && !hold) || (word_end && hold_full);
    shift          = (state == SHIFT) && !hold;
    // an accept in the same edge as a drain leaves the buffer full
    hold_full_next = accept || (hold_full && !load);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      in_ready  <= 1'b0;
      for (int unsigned l = 0; l < NLANES; l++) hold_data[l] <= '0;
    end else begin
      hold_full <= hold_full_next;
      in_ready  <= !hold_full_next;
      if (accept) hold_data <= din_lane;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bits      <= '0;
      out_valid <= 1'b0;
      first_bit <= 1'b0;
      last_bit  <= 1'b0;
      bit_index <= '0;
    end else if (!hold) begin
      unique case (state)
        IDLE: begin
          bits      <= '0;
          out_valid <= 1'b0;
          first_bit <= 1'b0;
          last_bit  <= 1'b0;
          bit_index <= '0;
          if (hold_full) begin
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          bits      <= lane_lsb;
          out_valid <= 1'b1;
          first_bit <= (cnt == '0);
          last_bit  <= (cnt == LAST_IDX);
          bit_index <= cnt;
          if (cnt == LAST_IDX) begin
            cnt <= '0;
            if (!hold_full) state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  for (genvar l = 0; l < NLANES; l++) begin : g_lane
    bitserial_lane_shifter #(.BITWIDTH(BITWIDTH)) u_shifter (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .shift(shift),
      .din  (hold_data[l]),
      .lsb  (lane_lsb[l])
    );
  end

  assign out_bit1 = bits[0];
  assign out_bit2 = bits[1];
  assign out_bit3 = bits[2];

endmodule

// File: tb/tb_bitserial_row_feeder.sv
// Randomised and directed bench for bitserial_row_feeder against a word-level reference model.
module tb_bitserial_row_feeder;

  localparam int unsigned W   = 8;
  localparam int unsigned CWT = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           hold = 1'b0;
  logic [W-1:0]   din1 = '0, din2 = '0, din3 = '0;
  logic           in_ready;
  logic           out_bit1, out_bit2, out_bit3;
  logic           out_valid, first_bit, last_bit;
  logic [CWT-1:0] bit_index;

  int checks   = 0;
  int failures = 0;

  bitserial_row_feeder #(.BITWIDTH(W), .CW(CWT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din1     (din1),
    .din2     (din2),
    .din3     (din3),
    .hold     (hold),
    .out_bit1 (out_bit1),
    .out_bit2 (out_bit2),
    .out_bit3 (out_bit3),
    .out_valid(out_valid),
    .first_bit(first_bit),
    .last_bit (last_bit),
    .bit_index(bit_index)
  );

  always #5 clk = ~clk;

  // Reference model: a pending slot, the word in flight and its bit position.
  logic           m_ready, m_full, m_active, m_fresh, m_acc;
  logic [W-1:0]   m_buf  [3];
  logic [W-1:0]   m_word [3];
  int             m_pos;
  logic [2:0]     e_bits;
  logic           e_valid, e_first, e_last;
  logic [CWT-1:0] e_idx;
  logic [3*W-1:0] sent_q [$];
  logic [W-1:0]   asm_w  [3];

  int seq1 [8] = '{0, 0, 1, 0, 0, 0, 0, 0};
  int seq2 [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
  int seq3 [8] = '{1, 0, 1, 1, 1, 1, 1, 1};

  task automatic model_reset();
    m_ready = 1'b0; m_full = 1'b0; m_active = 1'b0; m_fresh = 1'b0; m_acc = 1'b0;
    m_pos = 0;
    e_bits = '0; e_valid = 1'b0; e_first = 1'b0; e_last = 1'b0; e_idx = '0;
    for (int unsigned l = 0; l < 3; l++) begin
      m_buf[l] = '0; m_word[l] = '0; asm_w[l] = '0;
    end
    sent_q.delete();
  endtask

  task automatic model_step();
    logic acc, was_full;
    acc      = in_valid && m_ready;
    was_full = m_full;
    m_fresh  = 1'b0;
    if (!hold) begin
      if (!m_active) begin
        e_valid = 1'b0; e_bits = '0; e_first = 1'b0; e_last = 1'b0; e_idx = '0;
        if (was_full) begin
          m_word = m_buf; m_full = 1'b0; m_active = 1'b1; m_pos = 0;
        end
      end else begin
        for (int unsigned l = 0; l < 3; l++) e_bits[l] = m_word[l][m_pos];
        e_valid = 1'b1;
        e_first = (m_pos == 0);
        e_last  = (m_pos == int'(W) - 1);
        e_idx   = CWT'(m_pos);
        m_fresh = 1'b1;
        if (m_pos == int'(W) - 1) begin
          if (was_full) begin
            m_word = m_buf; m_full = 1'b0; m_pos = 0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_pos++;
        end
      end
    end
    if (acc) begin
      m_buf[0] = din1; m_buf[1] = din2; m_buf[2] = din3;
      m_full = 1'b1;
      sent_q.push_back({din3, din2, din1});
    end
    m_acc   = acc;
    m_ready = !m_full;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare plus word reassembly against the accepted-triplet queue.
  initial begin
    logic [3*W-1:0] want;
    forever begin
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, first_bit, last_bit, bit_index, out_bit3, out_bit2, out_bit1} !==
          {m_ready, e_valid, e_first, e_last, e_idx, e_bits}) begin
        failures++;
        $display("FAIL cycle_compare t=%0t got rdy=%b v=%b f=%b l=%b idx=%0d bits=%b%b%b exp rdy=%b v=%b f=%b l=%b idx=%0d bits=%b",
                 $time, in_ready, out_valid, first_bit, last_bit, bit_index, out_bit3, out_bit2, out_bit1,
                 m_ready, e_valid, e_first, e_last, e_idx, e_bits);
      end
      if (m_fresh && !rst) begin
        asm_w[0][e_idx] = out_bit1;
        asm_w[1][e_idx] = out_bit2;
        asm_w[2][e_idx] = out_bit3;
        if (e_last) begin
          checks++;
          if (sent_q.size() == 0) begin
            failures++;
            $display("FAIL word_order t=%0t got word %h expected none pending", $time,
                     {asm_w[2], asm_w[1], asm_w[0]});
          end else begin
            want = sent_q.pop_front();
            if ({asm_w[2], asm_w[1], asm_w[0]} !== want) begin
              failures++;
              $display("FAIL word_data t=%0t got %h expected %h", $time,
                       {asm_w[2], asm_w[1], asm_w[0]}, want);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    int n;
    n = 0;
    din1 = a; din2 = b; din3 = c; in_valid = 1'b1;
    do begin
      @(posedge clk); #1; n++;
    end while (!m_acc && n < 64);
    if (!m_acc) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_neg_until_last();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && last_bit) && n < 40);
    if (!(out_valid && last_bit)) check("last_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input string name);
    in_valid = 1'b0; hold = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check(name, sent_q.size(), 0);
  endtask

  initial begin
    int n, run, firsts;
    // reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready", in_ready, 0);
    check("reset_valid", out_valid, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", in_ready, 1);

    // single word with literal bit patterns
    send(8'd4, 8'd3, 8'hFD);
    @(negedge clk); check("lat_accept", out_valid, 0);
    @(negedge clk); check("lat_load", out_valid, 0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("sw_valid", out_valid, 1);
      check("sw_bit1", out_bit1, 32'(seq1[k]));
      check("sw_bit2", out_bit2, 32'(seq2[k]));
      check("sw_bit3", out_bit3, 32'(seq3[k]));
      check("sw_first", first_bit, (k == 0) ? 1 : 0);
      check("sw_last", last_bit, (k == 7) ? 1 : 0);
    end
    @(negedge clk); check("sw_end", out_valid, 0);

    // back-to-back words
    fork
      begin
        send(8'd2, 8'hFB, 8'hFD);
        send(8'd4, 8'd7, 8'hFD);
        send(8'd8, 8'd3, 8'hFD);
      end
      begin
        n = 0; run = 0; firsts = 0;
        do begin @(negedge clk); n++; end while (!out_valid && n < 40);
        while (out_valid && run < 40) begin
          run++;
          if (first_bit) firsts++;
          @(negedge clk);
        end
        check("b2b_run", run, 24);
        check("b2b_firsts", firsts, 3);
      end
    join
    drain("b2b_drained");

    // backpressure: valid held with data changing every cycle
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      din1 = W'($urandom); din2 = W'($urandom); din3 = W'($urandom);
      @(posedge clk); #1;
    end
    drain("bp_drained");

    // hold at bit 3 of 0x7F
    send(8'h7F, 8'h7F, 8'h7F);
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && bit_index == 3) && n < 40);
    check("hold_reach", bit_index, 3);
    hold = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_idx", bit_index, 3);
      check("hold_bit", {out_bit3, out_bit2, out_bit1}, 3'b111);
      check("hold_valid", out_valid, 1);
    end
    hold = 1'b0;
    for (int k = 4; k < 8; k++) begin
      @(negedge clk);
      check("hold_resume_idx", bit_index, k);
      check("hold_resume_last", last_bit, (k == 7) ? 1 : 0);
    end
    drain("hold_drained");

    // reset mid-word with the buffer full
    send(8'h11, 8'h22, 8'h33);
    send(8'h44, 8'h55, 8'h66);
    n = 0;
    do begin @(negedge clk); n++; end while (!(out_valid && bit_index == 4) && n < 40);
    check("mid_reach", bit_index, 4);
    #1 rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_ready", in_ready, 0);
    check("arst_bits", {out_bit3, out_bit2, out_bit1, first_bit, last_bit}, 0);
    check("arst_idx", bit_index, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (12) begin @(negedge clk); check("post_reset_idle", out_valid, 0); end
    send(8'hA5, 8'h5A, 8'hC3);
    drain("post_reset_drained");

    // extremes: sign bit rides with last_bit
    send(8'h80, 8'h80, 8'h80);
    wait_neg_until_last();
    check("sign_neg", {out_bit3, out_bit2, out_bit1}, 3'b111);
    send(8'h7F, 8'h7F, 8'h7F);
    wait_neg_until_last();
    check("sign_pos", {out_bit3, out_bit2, out_bit1}, 3'b000);
    drain("ext_drained");

    // random traffic with random hold; data held until accepted
    for (int i = 0; i < 1500; i++) begin
      if (!in_valid || m_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        din1 = W'($urandom); din2 = W'($urandom); din3 = W'($urandom);
      end
      hold = ($urandom_range(0, 4) == 0);
      @(posedge clk); #1;
    end
    drain("rand_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog t=%0t got no finish expected finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bitserial_row_feeder.md
Name: bitserial_row_feeder

Overview:
- Transmit end of the PE bit-serial input interface.
- Accepts parallel signed triplets (one word per filter tap row) through a valid/ready handshake.
- Shifts each triplet out LSB-first over BITWIDTH cycles on three serial lanes, with framing strobes (first bit, last/sign bit, bit index) for the bit-serial row filter datapath.
- Sits between the line-buffer/controller and the PE array, on the fast PE clock.

Parameters:
- BITWIDTH, 8, width of each signed input word and number of serial cycles per word (≥2).
- CW, clog2(BITWIDTH), width of the bit index output.

Ports:
- clk  in  1  PE (fast) clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  triplet din1..din3 valid.
- in_ready  out  1  feeder can accept a triplet this cycle.
- din1  in  BITWIDTH  signed word, lane 1.
- din2  in  BITWIDTH  signed word, lane 2.
- din3  in  BITWIDTH  signed word, lane 3.
- hold  in  1  downstream freeze; serial outputs and bit counter hold their values.
- out_bit1, out_bit2, out_bit3  out  1 each  serial bits, LSB first.
- out_valid  out  1  out_bit* carry a valid bit this cycle.
- first_bit  out  1  high with bit 0 of a word.
- last_bit  out  1  high with bit BITWIDTH-1 (the sign bit).
- bit_index  out  CW  index of the bit currently presented.

Behaviour:
- Reset (rst=1, asynchronous): all outputs 0, in_ready=0, FSM=IDLE, holding buffer empty. in_ready rises in the first cycle after rst deasserts. Reset mid-word discards the shift register and the buffer; no partial word resumes.
- Storage:
  - 1-entry holding buffer (hold_data, hold_full).
  - 3×BITWIDTH shift register.
  - Bit counter of CW bits.
- Handshake:
  - in_ready = !hold_full, registered.
  - A transfer occurs when in_valid && in_ready at a rising edge; din* are written to the buffer.
  - in_valid while in_ready=0 is ignored. The source must hold its data.
- FSM IDLE:
  - out_valid=0.
  - If hold_full and !hold: load the shift register from the buffer, clear hold_full, counter=0, go to SHIFT.
- FSM SHIFT, each edge with hold=0:
  - Present shreg[0] of each lane, then shift right.
  - Counter increments.
  - out_valid=1; first_bit=(counter==0); last_bit=(counter==BITWIDTH-1); bit_index=counter. All registered.
- Word end (counter==BITWIDTH-1, hold=0):
  - If hold_full: reload from the buffer in the same edge. The next word follows with no bubble.
  - Otherwise go to IDLE.
- Simultaneous buffer drain and new accept in the same edge: the buffer is written with the new triplet and hold_full stays 1. in_ready is computed from the post-edge state.
- hold=1: shift register, counter, FSM and all out_* frozen at their current values. A buffer accept is still permitted.
- Latency:
  - Accept edge N → buffer.
  - Edge N+1 → shift-register load (FSM IDLE).
  - Bit 0 is visible on out_bit* after edge N+2.
- Throughput: one triplet per BITWIDTH cycles, sustained, when the source refills within BITWIDTH-1 cycles.
- Arithmetic: no sign extension and no modification. Exactly BITWIDTH bits are sent; the receiver sign-extends using last_bit.
- Bit counter wrap: BITWIDTH-1 → 0 only on reload. With a non-power-of-2 BITWIDTH the counter never reaches 2^CW-1.

Decomposition:
- Shared PE package (pe_pkg):
  - clog2 function.
  - Default BITWIDTH.
  - FSM state encodings IDLE=0, SHIFT=1.
  - Lane count constant NLANES=3.
- One natural sub-module: bitserial_lane_shifter (a single BITWIDTH shift register with load/shift/hold), instantiated three times.
- Buffer, counter and FSM stay in the top module.

Test Plan (BITWIDTH=8):
- Single word: after reset, send din1=4, din2=3, din3=-3 (0xFD).
  - Bit 0 appears 2 cycles after the accept.
  - out_bit1 sequence = 0,0,1,0,0,0,0,0.
  - out_bit2 sequence = 1,1,0,0,0,0,0,0.
  - out_bit3 sequence = 1,0,1,1,1,1,1,1.
  - first_bit on cycle 0, last_bit on cycle 7, then out_valid=0.
- Back-to-back: send (2,-5,-3), (4,7,-3), (8,3,-3) as fast as in_ready allows.
  - out_valid stays 1 for 24 consecutive cycles.
  - first_bit pulses every 8 cycles.
  - Serial data matches the LSB-first encoding of each word.
- Backpressure: in_valid held high with changing data while in_ready=0.
  - Only values present at handshake edges are transmitted.
  - No word is duplicated or lost.
- Hold: assert hold for 5 cycles at bit_index=3 of 0x7F.
  - Outputs frozen at bit 3 for those 5 cycles.
  - The word completes with 8 total valid bits and the correct bits.
- Reset mid-word: assert rst at bit_index=4 while the buffer is full.
  - All outputs go to 0 immediately (asynchronously).
  - After release, nothing is transmitted until a new handshake; the next word is sent intact.
- Extremes: send -128 (0x80) and 127 (0x7F) on all lanes.
  - last_bit coincides with the sign bit, which is 1 for -128 and 0 for 127.
